escaneo_teclado: RTL and testbench
==================================

// Module: escaneo_teclado
// PURPOSE
//  Scans a 4x4 matrix keypad. Drives one column low at a time and reads the active-low rows.
//  Debounces each press and release. Emits a 4-bit key position code plus a single-cycle
//  key_detect pulse. Feeds the key-code translator: codigo[3:2]=row index, [1:0]=column index,
//  so key '1'=4'b0000, 'A'=4'b0011, '*'=4'b1100.
// PARAMETERS
//  SCAN_DIV      1000  clk cycles per scan tick (column dwell / sample period); legal >=2
//  DEBOUNCE_CNT  4     consecutive equal tick samples needed to accept press or release; legal >=2
// PORTS
//  clk         in   1  system clock; single clock domain
//  rst_n       in   1  synchronous, active-low reset
//  filas       in   4  keypad rows, active-low (pulled up), asynchronous to clk
//  columnas    out  4  keypad column drive, active-low one-hot
//  codigo      out  4  {row_idx[1:0], col_idx[1:0]} of last accepted key; held until next press
//  key_detect  out  1  one-cycle pulse when a press is accepted
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - columnas=4'b1110, codigo=4'b0000, key_detect=0.
//   - State=SCAN; div, deb and rel counters cleared; sync flops=4'b1111.
//   - Reset mid-press drops the press; if the key is still held after reset, it is re-detected
//     as a new press.
//  Input sync: 2-flop synchronizer on filas -> filas_s. All decisions use filas_s only.
//  div counter: free-runs 0..SCAN_DIV-1 in every state. tick = (div==SCAN_DIV-1).
//  FSM (evaluated only on tick; otherwise it holds):
//   SCAN
//    - filas_s==4'b1111: advance column 0->1->2->3->0. columnas changes the cycle after the tick.
//    - else: latch row = lowest-index zero bit of filas_s and col = current column;
//      deb=1; go DEBOUNCE. Column is frozen.
//   DEBOUNCE
//    - latched row bit 0: deb++. When deb reaches DEBOUNCE_CNT: go PRESSED,
//      codigo<={row,col}, key_detect=1 for exactly the next cycle.
//    - latched row bit 1: bounce. deb=0, go SCAN, advance column; no pulse, codigo unchanged.
//   PRESSED
//    - latched row bit 1: rel=1, go RELEASE. Else stay.
//   RELEASE
//    - latched row bit 1: rel++. When rel reaches DEBOUNCE_CNT: go SCAN, advance column.
//    - latched row bit 0: go PRESSED with no new pulse (release bounce).
//  Priorities and conflicts:
//   - Column frozen from DEBOUNCE through RELEASE; keys in other columns are ignored.
//   - Other rows in the frozen column are ignored; only the latched row is watched.
//   - Several rows low in one column: lowest row index wins.
//   - Several columns pressed: first column reached in scan order wins.
//  Pulse rules: key_detect and the codigo update are registered in the same edge.
//   At most one pulse per accepted press, however long the key is held.
//  Latency: pulse edge = (DEBOUNCE_CNT-1)*SCAN_DIV cycles after the detecting tick.
//  codigo is never cleared except by reset.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=3)
//  T1 Reset, no key: columnas cycles 1110->1101->1011->0111->1110, changing 1 cycle after each
//     tick; key_detect stays 0; codigo=0000.
//  T2 Hold '5' (pull filas[1] low while columnas[1]=0): key_detect high for 1 cycle, 8 cycles
//     after the detecting tick; codigo=4'b0101; columnas frozen at 4'b1101 while held.
//  T3 Hold '5' for 200 cycles, then release cleanly: exactly 1 pulse. After 3 released ticks,
//     scanning resumes at column 2 (columnas=4'b1011).
//  T4 Press bounce: filas[1] low for exactly one tick sample -> no pulse, codigo unchanged,
//     scan continues. Release bounce: 1 high sample, then low again -> no second pulse.
//  T5 Hold '1' and '9' together from reset: codigo=4'b0000 with one pulse ('1' wins, column 0
//     scanned first). Pressing 'B' while '1' is held gives no pulse.
//  T6 Hold '#' (codigo 1110); assert rst_n=0 mid-DEBOUNCE for 2 cycles, then release reset:
//     outputs show reset values; then one pulse with codigo=4'b1110.

Source files
------------

// File: rtl/escaneo_teclado_if.sv
// Keypad-side signal bundle for escaneo_teclado: row sense in, column drive and
// decoded key position out.
interface escaneo_teclado_if;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] codigo;
  logic       key_detect;

  modport master (output filas, input columnas, input codigo, input key_detect);
  modport slave  (input filas, output columnas, output codigo, output key_detect);
endinterface

// File: rtl/escaneo_teclado.sv
// 4x4 matrix keypad scanner with press/release debounce; reports {row,col} of each
// accepted press together with a one-cycle key_detect pulse.
module escaneo_teclado #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input logic               clk,
  input logic               rst_n,
  escaneo_teclado_if.slave  kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [DEB_W-1:0] rel_q, rel_d;
  logic [3:0]       filas_m_q, filas_s_q;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       columnas_q, columnas_d;
  logic [3:0]       codigo_q, codigo_d;
  logic             key_detect_q, key_detect_d;

  logic             tick;
  logic             row_bit;
  logic [1:0]       row_sel;
  logic             row_found;
  logic [DEB_W-1:0] deb_inc, rel_inc;

  assign tick    = (div_q == DIV_W'(SCAN_DIV - 1));
  assign row_bit = filas_s_q[row_q];
  assign deb_inc = deb_q + DEB_W'(1);
  assign rel_inc = rel_q + DEB_W'(1);

  // Lowest-index active row wins when several rows are low in the same column.
  always_comb begin
    row_sel   = 2'd0;
    row_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_found && !filas_s_q[i]) begin
        row_sel   = 2'(i);
        row_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    deb_d        = deb_q;
    rel_d        = rel_q;
    col_d        = col_q;
    row_d        = row_q;
    codigo_d     = codigo_q;
    key_detect_d = 1'b0;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (filas_s_q == 4'b1111) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = row_sel;
            deb_d   = DEB_W'(1);
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!row_bit) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_W'(DEBOUNCE_CNT)) begin
              state_d      = PRESSED;
              codigo_d     = {row_q, col_q};
              key_detect_d = 1'b1;
            end
          end else begin
            deb_d   = '0;
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        PRESSED: begin
          if (row_bit) begin
            rel_d   = DEB_W'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (row_bit) begin
            rel_d = rel_inc;
            if (rel_inc == DEB_W'(DEBOUNCE_CNT)) begin
              rel_d   = '0;
              deb_d   = '0;
              state_d = SCAN;
              col_d   = col_q + 2'd1;
            end
          end else begin
            // Release bounce: back to held without a new pulse.
            rel_d   = '0;
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    columnas_d        = '1;
    columnas_d[col_d] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SCAN;
      div_q        <= '0;
      deb_q        <= '0;
      rel_q        <= '0;
      filas_m_q    <= '1;
      filas_s_q    <= '1;
      col_q        <= 2'd0;
      row_q        <= 2'd0;
      columnas_q   <= 4'b1110;
      codigo_q     <= '0;
      key_detect_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      deb_q        <= deb_d;
      rel_q        <= rel_d;
      filas_m_q    <= kp.filas;
      filas_s_q    <= filas_m_q;
      col_q        <= col_d;
      row_q        <= row_d;
      columnas_q   <= columnas_d;
      codigo_q     <= codigo_d;
      key_detect_q <= key_detect_d;
    end
  end

  assign kp.columnas   = columnas_q;
  assign kp.codigo     = codigo_q;
  assign kp.key_detect = key_detect_q;

endmodule

// File: tb/tb_escaneo_teclado.sv
// Bench for escaneo_teclado: emulated keypad matrix, tick-level behavioural
// reference model, directed scenarios followed by random key presses.
module tb_escaneo_teclado;

  localparam int unsigned SD = 4;
  localparam int unsigned DC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  escaneo_teclado_if kp ();

  escaneo_teclado #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp.slave)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Keypad: keys[r*4+c] = 1 means the key at row r, column c is held down.
  logic [15:0] keys = '0;

  // Reference model state (tick-level view of the scanner).
  int          m_col, m_row, m_streak, m_rel, m_n;
  bit          m_locked, m_accepted, m_pulse;
  logic [3:0]  m_code;
  logic [3:0]  s1, s2;

  int unsigned cyc = 0;
  int unsigned dut_pulses = 0;
  int unsigned last_pulse_cyc = 0;
  int unsigned det_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rows_for(input int c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ~keys[i*4 + c];
    return r;
  endfunction

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] v;
    v    = '1;
    v[c] = 1'b0;
    return v;
  endfunction

  task automatic model_edge();
    logic [3:0] samp;
    m_pulse = 0;
    if (!rst_n) begin
      m_col = 0; m_locked = 0; m_accepted = 0; m_code = 4'h0;
      m_streak = 0; m_rel = 0; m_n = 0;
      s1 = 4'hF; s2 = 4'hF;
      return;
    end
    m_n++;
    samp = s2;
    s2   = s1;
    s1   = kp.filas;
    if (m_n % SD != 0) return;
    if (!m_locked) begin
      if (samp == 4'hF) m_col = (m_col + 1) % 4;
      else begin
        for (int r = 3; r >= 0; r--) if (!samp[r]) m_row = r;
        m_locked = 1; m_accepted = 0; m_streak = 1;
        det_cyc  = cyc;
      end
    end else if (!m_accepted) begin
      if (!samp[m_row]) begin
        m_streak++;
        if (m_streak == DC) begin
          m_accepted = 1; m_rel = 0; m_pulse = 1;
          m_code = {2'(m_row), 2'(m_col)};
        end
      end else begin
        m_locked = 0;
        m_col = (m_col + 1) % 4;
      end
    end else begin
      if (samp[m_row]) begin
        m_rel++;
        if (m_rel == DC) begin
          m_locked = 0; m_accepted = 0;
          m_col = (m_col + 1) % 4;
        end
      end else m_rel = 0;
    end
  endtask

  // One clock: present the row pattern for the model's driven column, advance,
  // then compare all outputs 1 time unit after the edge.
  task automatic step();
    kp.filas = rows_for(m_col);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("columnas", kp.columnas, col_drive(m_col));
    chk("codigo", kp.codigo, m_code);
    chk("key_detect", kp.key_detect, m_pulse);
    if (kp.key_detect === 1'b1) begin
      dut_pulses++;
      last_pulse_cyc = cyc;
    end
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic wait_accept(input string tag);
    for (int unsigned i = 0; i < 200 && !m_accepted; i++) step();
    chk(tag, m_accepted, 1'b1);
  endtask

  task automatic wait_unlock(input string tag);
    for (int unsigned i = 0; i < 200 && m_locked; i++) step();
    chk(tag, m_locked, 1'b0);
  endtask

  initial begin
    int unsigned p0;
    int unsigned k;
    kp.filas = 4'hF;

    // T1: reset, idle scanning
    rst_n = 0;
    steps(2);
    chk("rst_columnas", kp.columnas, 4'b1110);
    chk("rst_codigo", kp.codigo, 4'b0000);
    chk("rst_key_detect", kp.key_detect, 1'b0);
    rst_n = 1;
    steps(3);
    chk("t1_pre_tick", kp.columnas, 4'b1110);
    step();
    chk("t1_col1", kp.columnas, 4'b1101);
    steps(4);
    chk("t1_col2", kp.columnas, 4'b1011);
    steps(4);
    chk("t1_col3", kp.columnas, 4'b0111);
    steps(4);
    chk("t1_wrap", kp.columnas, 4'b1110);
    steps(8);

    // T2/T3: hold '5', latency, single pulse, resume at column 2
    p0 = dut_pulses;
    keys[1*4 + 1] = 1'b1;
    wait_accept("t2_wait");
    step();
    chk("t2_latency", last_pulse_cyc - det_cyc, (DC - 1) * SD);
    chk("t2_codigo", kp.codigo, 4'b0101);
    steps(200);
    chk("t3_frozen", kp.columnas, 4'b1101);
    chk("t3_one_pulse", dut_pulses - p0, 1);
    keys = '0;
    wait_unlock("t3_release");
    chk("t3_resume_col2", kp.columnas, 4'b1011);
    steps(10);

    // T4: press bounce (one low sample) on '8'
    p0 = dut_pulses;
    keys[2*4 + 1] = 1'b1;
    for (int unsigned i = 0; i < 60 && !m_locked; i++) step();
    chk("t4_lock", m_locked, 1'b1);
    keys = '0;
    steps(20);
    chk("t4_no_pulse", dut_pulses - p0, 0);
    chk("t4_codigo_kept", kp.codigo, 4'b0101);

    // T4: release bounce on '8'
    keys[2*4 + 1] = 1'b1;
    wait_accept("t4b_accept");
    steps(6);
    keys = '0;
    for (int unsigned i = 0; i < 40 && m_rel == 0; i++) step();
    chk("t4b_rel_started", m_rel, 1);
    keys[2*4 + 1] = 1'b1;
    steps(16);
    chk("t4b_still_held", m_accepted, 1'b1);
    keys = '0;
    wait_unlock("t4b_release");
    chk("t4b_one_pulse", dut_pulses - p0, 1);
    chk("t4b_codigo", kp.codigo, 4'b1001);

    // T5: '1' and '9' held from reset, then 'B' ignored
    rst_n = 0;
    keys[0] = 1'b1;
    keys[2*4 + 2] = 1'b1;
    steps(2);
    rst_n = 1;
    p0 = dut_pulses;
    wait_accept("t5_accept");
    step();
    chk("t5_codigo", kp.codigo, 4'b0000);
    keys[1*4 + 3] = 1'b1;
    steps(40);
    chk("t5_one_pulse", dut_pulses - p0, 1);
    keys = '0;
    wait_unlock("t5_release");
    steps(8);

    // T6: reset during debounce of '#'
    keys[3*4 + 2] = 1'b1;
    for (int unsigned i = 0; i < 60 && !m_locked; i++) step();
    chk("t6_lock", m_locked, 1'b1);
    step();
    rst_n = 0;
    steps(2);
    chk("t6_rst_columnas", kp.columnas, 4'b1110);
    chk("t6_rst_codigo", kp.codigo, 4'b0000);
    chk("t6_rst_key_detect", kp.key_detect, 1'b0);
    rst_n = 1;
    p0 = dut_pulses;
    wait_accept("t6_accept");
    step();
    chk("t6_codigo", kp.codigo, 4'b1110);
    steps(10);
    chk("t6_one_pulse", dut_pulses - p0, 1);
    keys = '0;
    wait_unlock("t6_release");

    // Random presses, sometimes two keys, sometimes glitchy
    for (int unsigned it = 0; it < 25; it++) begin
      k = $urandom_range(0, 15);
      keys = '0;
      keys[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      steps($urandom_range(5, 60));
      if ($urandom_range(0, 2) == 0) begin
        keys = '0;
        steps($urandom_range(1, 10));
        keys[k] = 1'b1;
        steps($urandom_range(5, 40));
      end
      keys = '0;
      steps($urandom_range(1, 40));
    end
    keys = '0;
    wait_unlock("rand_final_release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
